ray_sample_scanner: RTL and testbench
=====================================

Name: ray_sample_scanner

Overview:
- Parametrised successor to the fixed-camera per-pixel ray generator.
- Autonomously scans a full frame in raster order, issuing SPP jittered camera-space primary rays per pixel over a valid/ready stream.
- Sits between the frame controller (start/frame_done) and the intersection pipeline.
- Configurable resolution, samples per pixel and camera constants, with backpressure-safe pipelining.

Parameters:
- H_RES, 800, horizontal pixel count (≥1)
- V_RES, 600, vertical pixel count (≥1)
- SPP, 4, samples per pixel (≥1)
- FRAC_W, 16, fractional bits of sample coordinate and output (Q.FRAC_W)
- DIR_W, 19, signed output direction component width
- SCALE_X / SCALE_Y, 193 / 193, unsigned 16-bit screen-to-camera scale, Q0.FRAC_W
- SHIFT_X / SHIFT_Y, 77321 / 57991, camera-space centring offset, Q.FRAC_W
- SEED_X / SEED_Y, 16'h1ACE / 16'hC0DE, non-zero PRNG seeds

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  begin frame; sampled only in IDLE
- busy  out  1  high in SCAN or DRAIN
- frame_done  out  1  one-cycle pulse when last ray of frame leaves the output register
- out_valid  out  1  ray valid
- out_ready  in  1  downstream accepts
- out_dir_x  out  DIR_W  signed camera-space x, Q.FRAC_W
- out_dir_y  out  DIR_W  signed camera-space y, Q.FRAC_W
- out_dir_z  out  DIR_W  constant -1.0 (-(1<<FRAC_W))
- out_pixel_x  out  clog2(H_RES)  pixel tag
- out_pixel_y  out  clog2(V_RES)  pixel tag
- out_sample  out  max(1,clog2(SPP))  sample index tag
- out_pix_last  out  1  last sample of this pixel
- out_frame_last  out  1  last ray of frame

Behaviour:
- Clock is clk. Reset is asynchronous, active-high, named rst. All outputs are 0 in reset except out_dir_z.
- FSM states:
  - IDLE: start=1 goes to SCAN and clears counters.
  - SCAN: issues one sample per advance cycle. Counter order: sample fastest, then pixel_x, then pixel_y. Issuing the final sample (SPP-1, H_RES-1, V_RES-1) goes to DRAIN.
  - DRAIN: returns to IDLE in the cycle the out_frame_last ray is accepted; frame_done pulses that same cycle.
- start outside IDLE is ignored.
- advance = !out_valid || out_ready. When advance=0, all pipeline registers, counters and PRNGs hold.
- While out_valid && !out_ready, every out_* holds stable.
- Pipeline, 2 stages:
  - S1 registers sample_x = {pixel_x, off_x} (COORD_W = clog2(H_RES)+FRAC_W bits), sample_y likewise, plus tags.
  - S2 computes prod = sample*SCALE (COORD_W+16 bits) and dir = (prod >> FRAC_W) - SHIFT, truncated to DIR_W signed, then registers it with tags and out_valid.
  - With out_ready held high, the ray issued in cycle N is valid at N+2. Throughput is 1 ray/cycle.
- PRNGs: one 16-bit xorshift per axis, x ^= x<<7; x ^= x>>9; x ^= x<<8. Each reset to its seed and advances once per issued sample only. PRNGs are not reset on start, so frames decorrelate.
- SPP=1: out_sample is constant 0 and out_pix_last is always 1.
- H_RES=V_RES=1: frame of SPP rays; frame_last is set on sample SPP-1.
- Reset mid-frame: the pipeline is flushed (out_valid=0), the FSM goes to IDLE and no frame_done is produced.

Optional Feature:
- Macro RAY_JITTER_EN.
- Defined: off_x/off_y = PRNG outputs, giving a uniform [0,1) subpixel offset.
- Undefined: PRNGs are not instantiated and off_x = off_y = 1<<(FRAC_W-1) (pixel centre). All SPP samples of a pixel are then identical but still emitted and tagged.

Test Plan:
- Jitter off, defaults, out_ready=1, start pulse:
  - First ray at start+3 cycles (IDLE→SCAN, then 2-cycle latency): pixel(0,0) sample 0, dir_x=-77225, dir_y=-57895, dir_z=-65536.
  - The following 3 rays are identical with sample 1..3; out_pix_last only on sample 3.
- Jitter off, defaults: ray for pixel(799,599) gives dir_x=76982, dir_y=57712, with out_frame_last=1.
- H_RES=4, V_RES=2, SPP=2, out_ready=1:
  - Exactly 16 valid rays in order s→x→y.
  - frame_done pulses once on the 16th acceptance; busy falls the next cycle.
  - start pulses during the frame are ignored.
- Backpressure: random out_ready (50%) on the small config.
  - Output stream is identical to the ready=1 run, including PRNG offsets with jitter on.
  - No outputs change while valid && !ready.
- Jitter on: first two issued samples use xorshift(1ACE) and xorshift(xorshift(1ACE)) for off_x (model-checked), and the same for off_y from C0DE.
  - A second frame continues the PRNG sequence rather than restarting it.
- Assert rst mid-frame after 5 rays:
  - out_valid=0 and busy=0 immediately.
  - No frame_done.
  - A new start reproduces the first-frame sequence from the seeds.

Source files
------------

// File: rtl/ray_sample_scanner.sv
// Raster-order camera ray generator: SPP samples per pixel, 2-stage valid/ready pipeline.
// Define RAY_JITTER_EN for xorshift subpixel jitter; otherwise samples sit at pixel centre.
module ray_sample_scanner #(
    parameter int          H_RES   = 800,
    parameter int          V_RES   = 600,
    parameter int          SPP     = 4,
    parameter int          FRAC_W  = 16,
    parameter int          DIR_W   = 19,
    parameter logic [15:0] SCALE_X = 16'd193,
    parameter logic [15:0] SCALE_Y = 16'd193,
    parameter int          SHIFT_X = 77321,
    parameter int          SHIFT_Y = 57991,
    parameter logic [15:0] SEED_X  = 16'h1ACE,
    parameter logic [15:0] SEED_Y  = 16'hC0DE,
    localparam int PX_W = (H_RES > 1) ? $clog2(H_RES) : 1,
    localparam int PY_W = (V_RES > 1) ? $clog2(V_RES) : 1,
    localparam int S_W  = (SPP > 1) ? $clog2(SPP) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [DIR_W-1:0] out_dir_x,
    output logic signed [DIR_W-1:0] out_dir_y,
    output logic signed [DIR_W-1:0] out_dir_z,
    output logic [PX_W-1:0]         out_pixel_x,
    output logic [PY_W-1:0]         out_pixel_y,
    output logic [S_W-1:0]          out_sample,
    output logic                    out_pix_last,
    output logic                    out_frame_last
);
    // state | meaning
    // IDLE  | waiting for start
    // SCAN  | issuing one sample per advance cycle
    // DRAIN | all samples issued, waiting for the frame-last ray to be accepted
    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    localparam int COORD_W = PX_W + FRAC_W;
    localparam int PROD_W  = COORD_W + 16;
    localparam int DIR_Z_INT = -(1 << FRAC_W);
    localparam logic [PX_W-1:0] X_MAX = PX_W'(H_RES - 1);
    localparam logic [PY_W-1:0] Y_MAX = PY_W'(V_RES - 1);
    localparam logic [S_W-1:0]  S_MAX = S_W'(SPP - 1);

    generate
        if (SEED_X == 16'd0 || SEED_Y == 16'd0) begin : g_seed_check
            $error("xorshift seeds must be non-zero");
        end
    endgenerate

    state_t            state;
    logic [S_W-1:0]    cnt_s;
    logic [PX_W-1:0]   cnt_x;
    logic [PY_W-1:0]   cnt_y;
    logic              s1_valid;
    logic [COORD_W-1:0] s1_x, s1_y;
    logic [S_W-1:0]    s1_s;
    logic              s1_pl, s1_fl;

    logic advance, issue, last_s, last_x, last_y;
    logic [FRAC_W-1:0] off_x, off_y;
    logic [PROD_W-1:0] prod_x, prod_y;
    logic [DIR_W-1:0]  dir_x, dir_y;

    assign advance    = !out_valid || out_ready;
    assign issue      = advance && (state == SCAN);
    assign last_s     = (cnt_s == S_MAX);
    assign last_x     = (cnt_x == X_MAX);
    assign last_y     = (cnt_y == Y_MAX);
    assign busy       = (state != IDLE);
    assign frame_done = (state == DRAIN) && out_valid && out_ready && out_frame_last;
    assign out_dir_z  = DIR_W'(DIR_Z_INT);

`ifdef RAY_JITTER_EN
    logic [15:0] prng_x, prng_y, prng_x_nxt, prng_y_nxt;

    function automatic logic [15:0] xorshift(input logic [15:0] v);
        logic [15:0] t;
        t = v ^ (v << 7);
        t = t ^ (t >> 9);
        t = t ^ (t << 8);
        return t;
    endfunction

    assign prng_x_nxt = xorshift(prng_x);
    assign prng_y_nxt = xorshift(prng_y);
    assign off_x      = FRAC_W'(prng_x_nxt);
    assign off_y      = FRAC_W'(prng_y_nxt);

    // Seeded only by reset so consecutive frames draw fresh offsets.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prng_x <= SEED_X;
            prng_y <= SEED_Y;
        end else if (issue) begin
            prng_x <= prng_x_nxt;
            prng_y <= prng_y_nxt;
        end
    end
`else
    assign off_x = {1'b1, {(FRAC_W-1){1'b0}}};
    assign off_y = {1'b1, {(FRAC_W-1){1'b0}}};
`endif

    assign prod_x = PROD_W'(s1_x) * PROD_W'(SCALE_X);
    assign prod_y = PROD_W'(s1_y) * PROD_W'(SCALE_Y);
    assign dir_x  = DIR_W'((prod_x >> FRAC_W) - PROD_W'(SHIFT_X));
    assign dir_y  = DIR_W'((prod_y >> FRAC_W) - PROD_W'(SHIFT_Y));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cnt_s          <= '0;
            cnt_x          <= '0;
            cnt_y          <= '0;
            s1_valid       <= 1'b0;
            s1_x           <= '0;
            s1_y           <= '0;
            s1_s           <= '0;
            s1_pl          <= 1'b0;
            s1_fl          <= 1'b0;
            out_valid      <= 1'b0;
            out_dir_x      <= '0;
            out_dir_y      <= '0;
            out_pixel_x    <= '0;
            out_pixel_y    <= '0;
            out_sample     <= '0;
            out_pix_last   <= 1'b0;
            out_frame_last <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= SCAN;
                        cnt_s <= '0;
                        cnt_x <= '0;
                        cnt_y <= '0;
                    end
                end
                SCAN: begin
                    if (advance) begin
                        if (last_s) begin
                            cnt_s <= '0;
                            if (last_x) begin
                                cnt_x <= '0;
                                cnt_y <= last_y ? '0 : cnt_y + PY_W'(1);
                                if (last_y)
                                    state <= DRAIN;
                            end else begin
                                cnt_x <= cnt_x + PX_W'(1);
                            end
                        end else begin
                            cnt_s <= cnt_s + S_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (frame_done)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (advance) begin
                s1_valid <= issue;
                if (issue) begin
                    s1_x  <= {cnt_x, off_x};
                    s1_y  <= {cnt_y, off_y};
                    s1_s  <= cnt_s;
                    s1_pl <= last_s;
                    s1_fl <= last_s && last_x && last_y;
                end
                out_valid      <= s1_valid;
                out_dir_x      <= dir_x;
                out_dir_y      <= dir_y;
                out_pixel_x    <= s1_x[COORD_W-1:FRAC_W];
                out_pixel_y    <= s1_y[COORD_W-1:FRAC_W];
                out_sample     <= s1_s;
                out_pix_last   <= s1_pl;
                out_frame_last <= s1_fl;
            end
        end
    end
endmodule

// File: tb/tb_ray_sample_scanner.sv
// Scoreboard bench: a wide 800x2x4 scanner for latency/boundary rays and a 4x2x2 scanner for
// frame sequencing, backpressure, PRNG continuity and mid-frame reset.
module tb_ray_sample_scanner;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic b_start, b_ready, b_busy, b_fd, b_valid, b_pl, b_fl;
    logic signed [18:0] b_dx, b_dy, b_dz;
    logic [9:0] b_px;
    logic [0:0] b_py;
    logic [1:0] b_s;

    logic s_start, s_ready, s_busy, s_fd, s_valid, s_pl, s_fl;
    logic signed [18:0] s_dx, s_dy, s_dz;
    logic [1:0] s_px;
    logic [0:0] s_py;
    logic [0:0] s_s;

    ray_sample_scanner #(.H_RES(800), .V_RES(2), .SPP(4)) u_big (
        .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .frame_done(b_fd),
        .out_valid(b_valid), .out_ready(b_ready), .out_dir_x(b_dx), .out_dir_y(b_dy),
        .out_dir_z(b_dz), .out_pixel_x(b_px), .out_pixel_y(b_py), .out_sample(b_s),
        .out_pix_last(b_pl), .out_frame_last(b_fl));

    ray_sample_scanner #(.H_RES(4), .V_RES(2), .SPP(2)) u_small (
        .clk(clk), .rst(rst), .start(s_start), .busy(s_busy), .frame_done(s_fd),
        .out_valid(s_valid), .out_ready(s_ready), .out_dir_x(s_dx), .out_dir_y(s_dy),
        .out_dir_z(s_dz), .out_pixel_x(s_px), .out_pixel_y(s_py), .out_sample(s_s),
        .out_pix_last(s_pl), .out_frame_last(s_fl));

    typedef struct {
        int idx;
        int dx, dy, px, py, s, pl, fl;
    } exp_t;

    exp_t qb[$];
    exp_t qs[$];
    int total = 0;
    int bad = 0;
    logic [15:0] mx, my, bx, by;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cmp_ray(input string tag, input exp_t e, input int dx, input int dy,
                           input int dz, input int px, input int py, input int s,
                           input int pl, input int fl);
        check({tag, "_dir_x"}, dx, e.dx);
        check({tag, "_dir_y"}, dy, e.dy);
        check({tag, "_dir_z"}, dz, -65536);
        check({tag, "_pixel_x"}, px, e.px);
        check({tag, "_pixel_y"}, py, e.py);
        check({tag, "_sample"}, s, e.s);
        check({tag, "_pix_last"}, pl, e.pl);
        check({tag, "_frame_last"}, fl, e.fl);
    endtask

    function automatic logic [15:0] xs(input logic [15:0] v);
        logic [15:0] t;
        t = v ^ (v << 7);
        t = t ^ (t >> 9);
        t = t ^ (t << 8);
        return t;
    endfunction

    function automatic int exp_dir(input int pix, input int off, input int shift);
        longint v;
        v = (longint'(pix) * 65536 + longint'(off)) * 193;
        return int'(v >>> 16) - shift;
    endfunction

    function automatic exp_t mk(input int idx, input int dx, input int dy, input int px,
                                input int py, input int s, input int pl, input int fl);
        exp_t e;
        e.idx = idx; e.dx = dx; e.dy = dy; e.px = px; e.py = py;
        e.s = s; e.pl = pl; e.fl = fl;
        return e;
    endfunction

    task automatic push_small();
        int idx;
        logic [15:0] ox, oy;
        idx = 0;
        for (int y = 0; y < 2; y++)
            for (int x = 0; x < 4; x++)
                for (int s = 0; s < 2; s++) begin
`ifdef RAY_JITTER_EN
                    mx = xs(mx);
                    my = xs(my);
                    ox = mx;
                    oy = my;
`else
                    ox = 16'h8000;
                    oy = 16'h8000;
`endif
                    qs.push_back(mk(idx, exp_dir(x, int'(ox), 77321), exp_dir(y, int'(oy), 57991),
                                    x, y, s, int'(s == 1), int'(idx == 15)));
                    idx++;
                end
    endtask

    task automatic push_big();
`ifdef RAY_JITTER_EN
        int idx;
        idx = 0;
        for (int y = 0; y < 2; y++)
            for (int x = 0; x < 800; x++)
                for (int s = 0; s < 4; s++) begin
                    bx = xs(bx);
                    by = xs(by);
                    if (idx < 5 || idx == 3199 || idx == 6399)
                        qb.push_back(mk(idx, exp_dir(x, int'(bx), 77321),
                                        exp_dir(y, int'(by), 57991),
                                        x, y, s, int'(s == 3), int'(idx == 6399)));
                    idx++;
                end
`else
        for (int i = 0; i < 4; i++)
            qb.push_back(mk(i, -77225, -57895, 0, 0, i, int'(i == 3), 0));
        qb.push_back(mk(4, -77032, -57895, 1, 0, 0, 0, 0));
        qb.push_back(mk(3199, 76982, -57895, 799, 0, 3, 1, 0));
        qb.push_back(mk(6399, 76982, -57702, 799, 1, 3, 1, 1));
`endif
    endtask

    int acc_b = 0, fd_b_cnt = 0, first_b_cyc = -1;
    always @(negedge clk) begin
        if (!rst) begin
            if (b_valid && first_b_cyc < 0)
                first_b_cyc = cyc;
            if (b_valid && b_ready) begin
                if (qb.size() > 0 && qb[0].idx == acc_b) begin
                    cmp_ray("big", qb[0], b_dx, b_dy, b_dz, b_px, b_py, b_s, b_pl, b_fl);
                    void'(qb.pop_front());
                end
                acc_b++;
            end
            if (b_fd)
                fd_b_cnt++;
        end
    end

    int acc_s = 0, fd_s_cnt = 0, fd_s_idx = -1;
    logic prev_hold = 1'b0;
    logic [44:0] prev_vec, cur_vec;
    always @(negedge clk) begin
        cur_vec = {s_valid, s_dx, s_dy, s_px, s_py, s_s, s_pl, s_fl};
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                total++;
                if (cur_vec !== prev_vec) begin
                    bad++;
                    $display("FAIL hold_stable: got %h expected %h", cur_vec, prev_vec);
                end
            end
            if (s_valid && s_ready) begin
                if (qs.size() > 0) begin
                    check("small_idx", acc_s, qs[0].idx);
                    cmp_ray("small", qs[0], s_dx, s_dy, s_dz, s_px, s_py, s_s, s_pl, s_fl);
                    void'(qs.pop_front());
                end else begin
                    total++;
                    bad++;
                    $display("FAIL extra_ray: got ray %0d expected none", acc_s);
                end
                acc_s++;
            end
            if (s_fd) begin
                fd_s_cnt++;
                fd_s_idx = (s_valid && s_ready) ? acc_s - 1 : -1;
                check("fd_while_busy", int'(s_busy), 1);
            end
            prev_hold = s_valid && !s_ready;
            prev_vec  = cur_vec;
        end
    end

    task automatic run_small(input bit rand_ready, input bit extra_starts);
        acc_s = 0;
        fd_s_cnt = 0;
        fd_s_idx = -1;
        push_small();
        @(posedge clk); #1;
        s_start = 1'b1;
        for (int n = 0; n < 300; n++) begin
            @(posedge clk); #1;
            if (fd_s_cnt > 0) break;
            s_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            s_start = extra_starts && (n == 3 || n == 6 || n == 10);
        end
        s_start = 1'b0;
        s_ready = 1'b1;
        check("busy_after_done", int'(s_busy), 0);
        repeat (4) @(posedge clk);
        #1;
        check("frame_rays", acc_s, 16);
        check("queue_empty", qs.size(), 0);
        check("fd_count", fd_s_cnt, 1);
        check("fd_on_last", fd_s_idx, 15);
        qs.delete();
    endtask

    int start_cyc;
    initial begin
        rst = 1'b1;
        b_start = 1'b0; b_ready = 1'b1;
        s_start = 1'b0; s_ready = 1'b1;
        mx = 16'h1ACE; my = 16'hC0DE;
        bx = 16'h1ACE; by = 16'hC0DE;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", int'(s_valid), 0);
        check("rst_busy", int'(s_busy), 0);
        check("rst_done", int'(s_fd), 0);
        check("rst_dir_x", s_dx, 0);
        check("rst_dir_z", s_dz, -65536);
        check("rst_big_valid", int'(b_valid), 0);
        rst = 1'b0;

        push_big();
        @(posedge clk); #1;
        start_cyc = cyc;
        b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        for (int n = 0; n < 7000 && fd_b_cnt == 0; n++)
            @(posedge clk);
        #1;
        check("big_latency", first_b_cyc - start_cyc, 3);
        check("big_rays", acc_b, 6400);
        check("big_queue_empty", qb.size(), 0);
        check("big_fd", fd_b_cnt, 1);
        @(posedge clk); #1;
        check("big_busy_after", int'(b_busy), 0);

        run_small(1'b0, 1'b1);
        run_small(1'b0, 1'b0);

        acc_s = 0;
        fd_s_cnt = 0;
        push_small();
        @(posedge clk); #1;
        s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        for (int n = 0; n < 50 && acc_s < 5; n++) begin
            @(posedge clk); #1;
        end
        check("pre_reset_rays", acc_s, 5);
        rst = 1'b1;
        #1;
        check("midrst_valid", int'(s_valid), 0);
        check("midrst_busy", int'(s_busy), 0);
        qs.delete();
        mx = 16'h1ACE; my = 16'hC0DE;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("midrst_no_done", fd_s_cnt, 0);
        check("midrst_idle", int'(s_busy), 0);

        run_small(1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
